// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with request/hold/release handshake and registered one-hot grant.
// Optional forced revoke after MAX_HOLD grant cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_timeout, w_timeout_nxt;
  logic [7:0] r_gnt, w_gnt_nxt;
  logic       w_any;
  logic [2:0] w_winner;
  logic [2:0] w_cand;
  logic       w_expire;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_8: MAX_HOLD must be in 2..255");
  end

  function automatic logic [7:0] dec3to8(input logic [2:0] idx);
    logic [7:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First requester found scanning upward from r_ptr, wrapping modulo 8.
  always_comb begin
    w_any    = 1'b0;
    w_winner = r_ptr;
    w_cand   = r_ptr;
    for (int unsigned i = 0; i < 8; i++) begin
      w_cand = r_ptr + 3'(i);
      if (!w_any && req[w_cand]) begin
        w_any    = 1'b1;
        w_winner = w_cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt, w_hold_nxt;

  assign w_expire = (r_hold_cnt == 8'(MAX_HOLD));

  always_comb begin
    w_hold_nxt = '0;
    if (w_state_nxt == ST_GRANT)
      w_hold_nxt = (r_state == ST_IDLE) ? 8'd1 : r_hold_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hold_cnt <= '0;
    else        r_hold_cnt <= w_hold_nxt;
  end
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_valid_nxt   = r_valid;
    w_ptr_nxt     = r_ptr;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = w_winner;
          w_valid_nxt = 1'b1;
        end
      end
      ST_GRANT: begin
        // A release on the same edge as expiry wins, so timeout stays low then.
        if (!req[r_idx] || w_expire) begin
          w_state_nxt   = ST_IDLE;
          w_valid_nxt   = 1'b0;
          w_ptr_nxt     = r_idx + 3'd1;
          w_timeout_nxt = req[r_idx];
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
    w_gnt_nxt = w_valid_nxt ? dec3to8(w_idx_nxt) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_idx     <= 3'd7;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_idx     <= w_idx_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8 (MAX_HOLD=4; timeout scenario depends on ARB_TIMEOUT_EN).
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (3) step();
    checks++;
    if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt got %h want 00", gnt); end
    checks++;
    if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", gnt_valid); end
    checks++;
    if (gnt_idx !== 3'd7) begin errors++; $display("FAIL reset_idx got %0d want 7", gnt_idx); end
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
    rst_n = 1'b1;
    step();
    checks++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
      errors++; $display("FAIL reset_first_grant got gnt=%h idx=%0d v=%b want 01/0/1", gnt, gnt_idx, gnt_valid);
    end
    req = 8'h00;
    step();
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release got gnt=%h v=%b want 00/0", gnt, gnt_valid);
    end
    step();
  endtask

  task automatic test_single();
    req = 8'h20;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (gnt !== 8'h20 || gnt_idx !== 3'd5 || gnt_valid !== 1'b1) begin
        errors++; $display("FAIL single_hold[%0d] got gnt=%h idx=%0d v=%b want 20/5/1", i, gnt, gnt_idx, gnt_valid);
      end
    end
    req = 8'h00;
    step();
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd5) begin
      errors++; $display("FAIL single_release got gnt=%h v=%b idx=%0d want 00/0/5", gnt, gnt_valid, gnt_idx);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp;
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      exp = 8'h01 << (i % 8);
      step();
      checks++;
      if (gnt !== exp || gnt_idx !== 3'(i % 8)) begin
        errors++; $display("FAIL rotation_grant[%0d] got gnt=%h idx=%0d want %h/%0d", i, gnt, gnt_idx, exp, i % 8);
      end
      req = 8'hFF & ~exp;
      step();
      checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
        errors++; $display("FAIL rotation_gap[%0d] got gnt=%h v=%b want 00/0", i, gnt, gnt_valid);
      end
      req = 8'hFF;
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_priority();
    req = 8'h20;
    step();
    checks++;
    if (gnt !== 8'h20) begin errors++; $display("FAIL prio_owner5 got %h want 20", gnt); end
    req = 8'h41;
    step();
    checks++;
    if (gnt !== 8'h00) begin errors++; $display("FAIL prio_gap5 got %h want 00", gnt); end
    step();
    checks++;
    if (gnt !== 8'h40 || gnt_idx !== 3'd6) begin
      errors++; $display("FAIL prio_idx6 got gnt=%h idx=%0d want 40/6", gnt, gnt_idx);
    end
    req = 8'h01;
    step();
    step();
    checks++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      errors++; $display("FAIL prio_idx0 got gnt=%h idx=%0d want 01/0", gnt, gnt_idx);
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_reset_mid_grant();
    req = 8'h08;
    step();
    checks++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
      errors++; $display("FAIL midrst_owner3 got gnt=%h idx=%0d want 08/3", gnt, gnt_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd7) begin
      errors++; $display("FAIL midrst_async got gnt=%h v=%b idx=%0d want 00/0/7", gnt, gnt_valid, gnt_idx);
    end
    req = 8'h00;
    step();
    rst_n = 1'b1;
    step();
    req = 8'h81;
    step();
    checks++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      errors++; $display("FAIL midrst_restart got gnt=%h idx=%0d want 01/0", gnt, gnt_idx);
    end
    req = 8'h00;
    step();
    step();
  endtask

  task automatic test_hold_limit();
    logic [7:0] exp_g;
    logic       exp_t;
    do_reset();
    req = 8'h03;
    for (int i = 0; i < 12; i++) begin
      step();
`ifdef ARB_TIMEOUT_EN
      // Cycle pattern: 4x owner0, revoke pulse, 4x owner1, revoke pulse, owner0.
      if (i < 4)       begin exp_g = 8'h01; exp_t = 1'b0; end
      else if (i == 4) begin exp_g = 8'h00; exp_t = 1'b1; end
      else if (i < 9)  begin exp_g = 8'h02; exp_t = 1'b0; end
      else if (i == 9) begin exp_g = 8'h00; exp_t = 1'b1; end
      else             begin exp_g = 8'h01; exp_t = 1'b0; end
`else
      exp_g = 8'h01;
      exp_t = 1'b0;
`endif
      checks++;
      if (gnt !== exp_g || timeout !== exp_t) begin
        errors++; $display("FAIL hold[%0d] got gnt=%h to=%b want %h/%b", i, gnt, timeout, exp_g, exp_t);
      end
    end
    req = 8'h00;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    test_reset();
    test_single();
    test_rotation();
    test_priority();
    test_reset_mid_grant();
    test_hold_limit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
